rr_vc_arbiter: RTL and testbench

Parametrised output-port arbiter for the NoC router.
- Each cycle, `state` picks one virtual channel (even/odd phase for the default 2-VC build).
- Among that VC's requesting input buffers, a per-VC round-robin pointer picks one winner; its flit goes into a registered output slot.
- The output slot has a valid/ready handshake to the downstream link.
- Sits between the per-input VC buffers and the output link; supersedes the fixed 2x2, 64-bit arbiter.

---
 rtl/noc_pkg.sv | 24 ++
 rtl/rr_pick.sv | 33 +++
 rtl/rr_vc_arbiter.sv | 115 +++++++++++
 tb/tb_rr_vc_arbiter.sv | 348 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/noc_pkg.sv
// Shared NoC router parameters and flit field layout.
// Router-level blocks take their default sizing from here.
package noc_pkg;

  localparam int DATA_W  = 64;
  localparam int NUM_VC  = 2;
  localparam int NUM_REQ = 2;

  localparam int FLIT_TYPE_W   = 2;
  localparam int FLIT_TYPE_LSB = DATA_W - FLIT_TYPE_W;

  typedef enum logic [FLIT_TYPE_W-1:0] {
    FLIT_HEAD   = 2'd0,
    FLIT_BODY   = 2'd1,
    FLIT_TAIL   = 2'd2,
    FLIT_SINGLE = 2'd3
  } flit_type_e;

  // Index width for n items, never below one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Wrap-around priority pick: first request at or above ptr,
// then wrapping to the bottom. Purely combinational.
module rr_pick
  import noc_pkg::*;
#(
  parameter int N  = 2,
  parameter int PW = idx_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic          any
);

  // Upper pass from ptr, then lower pass below ptr.
  always_comb begin
    gnt = '0;
    any = 1'b0;
    for (int j = 0; j < N; j++) begin
      if (!any && req[j] && j >= int'(ptr)) begin
        gnt[j] = 1'b1;
        any    = 1'b1;
      end
    end
    for (int j = 0; j < N; j++) begin
      if (!any && req[j] && j < int'(ptr)) begin
        gnt[j] = 1'b1;
        any    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rr_vc_arbiter.sv
// Output-port arbiter: state picks a VC, a per-VC round-robin
// pointer picks a requester, winner loads a registered slot.
module rr_vc_arbiter
  import noc_pkg::*;
#(
  parameter int DATA_W  = noc_pkg::DATA_W,
  parameter int NUM_VC  = noc_pkg::NUM_VC,
  parameter int NUM_REQ = noc_pkg::NUM_REQ,
  parameter int VC_W    = idx_w(NUM_VC)
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [VC_W-1:0]                  state,
  input  logic [NUM_VC*NUM_REQ-1:0]        req,
  input  logic [NUM_VC*NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_VC*NUM_REQ-1:0]        grant,
  output logic [DATA_W-1:0]                dout,
  output logic                             dout_valid,
  input  logic                             out_ready
);

  localparam int PW = idx_w(NUM_REQ);

  logic [DATA_W-1:0]           dout_q, dout_d;
  logic                        valid_q, valid_d;
  logic [NUM_VC-1:0][PW-1:0]   ptr_q, ptr_d;

  logic [NUM_REQ-1:0]          elig;
  logic [NUM_REQ-1:0]          pick_gnt;
  logic                        pick_any;
  logic [PW-1:0]               ptr_sel;
  logic [PW-1:0]               win_idx;
  logic [PW-1:0]               ptr_nxt;
  logic [DATA_W-1:0]           win_data;
  logic                        slot_free;
  logic                        do_grant;

  // Route the selected VC's requests and pointer to the picker;
  // an out-of-range state or reset leaves the set empty.
  always_comb begin
    elig    = '0;
    ptr_sel = '0;
    for (int v = 0; v < NUM_VC; v++) begin
      if (!reset && state == VC_W'(v)) begin
        elig    = req[v*NUM_REQ +: NUM_REQ];
        ptr_sel = ptr_q[v];
      end
    end
  end

  rr_pick #(
    .N  (NUM_REQ),
    .PW (PW)
  ) u_pick (
    .req (elig),
    .ptr (ptr_sel),
    .gnt (pick_gnt),
    .any (pick_any)
  );

  assign slot_free = !valid_q || out_ready;
  assign do_grant  = pick_any && slot_free;

  // Spread the winner onto the flat grant vector, fetch its flit.
  always_comb begin
    grant    = '0;
    win_data = '0;
    win_idx  = '0;
    for (int v = 0; v < NUM_VC; v++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (do_grant && state == VC_W'(v) && pick_gnt[i]) begin
          grant[v*NUM_REQ+i] = 1'b1;
          win_data = req_data[(v*NUM_REQ+i)*DATA_W +: DATA_W];
          win_idx  = PW'(i);
        end
      end
    end
  end

  assign ptr_nxt = (win_idx == PW'(NUM_REQ-1)) ? '0
                 : win_idx + 1'b1;

  // Slot load/drain and pointer advance for the served VC.
  always_comb begin
    dout_d  = dout_q;
    valid_d = valid_q;
    ptr_d   = ptr_q;
    if (do_grant) begin
      dout_d  = win_data;
      valid_d = 1'b1;
      for (int v = 0; v < NUM_VC; v++) begin
        if (state == VC_W'(v)) ptr_d[v] = ptr_nxt;
      end
    end else if (valid_q && out_ready) begin
      valid_d = 1'b0;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      dout_q  <= '0;
      valid_q <= 1'b0;
      ptr_q   <= '0;
    end else begin
      dout_q  <= dout_d;
      valid_q <= valid_d;
      ptr_q   <= ptr_d;
    end
  end

  assign dout       = dout_q;
  assign dout_valid = valid_q;

endmodule

// File: tb/tb_rr_vc_arbiter.sv
// Directed bench for the default 2x2 build plus a scoreboarded
// random run on a 4-VC, 3-requester, 32-bit build.
module tb_rr_vc_arbiter;

  logic         clk;
  logic         reset;
  logic         state;
  logic [3:0]   req;
  logic [255:0] req_data;
  logic [3:0]   grant;
  logic [63:0]  dout;
  logic         dout_valid;
  logic         out_ready;

  logic         g_reset;
  logic [1:0]   g_state;
  logic [11:0]  g_req;
  logic [383:0] g_data;
  logic [11:0]  g_grant;
  logic [31:0]  g_dout;
  logic         g_valid;
  logic         g_ready;

  int errors = 0;
  int checks = 0;

  logic [63:0] dv [4];

  rr_vc_arbiter #(
    .DATA_W (64), .NUM_VC (2), .NUM_REQ (2)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .state      (state),
    .req        (req),
    .req_data   (req_data),
    .grant      (grant),
    .dout       (dout),
    .dout_valid (dout_valid),
    .out_ready  (out_ready)
  );

  rr_vc_arbiter #(
    .DATA_W (32), .NUM_VC (4), .NUM_REQ (3)
  ) gdut (
    .clk        (clk),
    .reset      (g_reset),
    .state      (g_state),
    .req        (g_req),
    .req_data   (g_data),
    .grant      (g_grant),
    .dout       (g_dout),
    .dout_valid (g_valid),
    .out_ready  (g_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    reset = 1'b1;
    tick;
    tick;
    reset = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1; req = 4'hf; state = 1'b0; out_ready = 1'b1;
    for (int c = 0; c < 2; c++) begin
      #1;
      checks++;
      if (grant !== 4'b0000) begin
        errors++;
        $display("FAIL rst_grant c=%0d got=%b exp=0000", c, grant);
      end
      tick;
      checks++;
      if (dout !== 64'h0 || dout_valid !== 1'b0) begin
        errors++;
        $display("FAIL rst_out c=%0d dout=%h v=%b exp 0/0",
                 c, dout, dout_valid);
      end
    end
    reset = 1'b0;
    #1;
    checks++;
    if (grant !== 4'b0001) begin
      errors++;
      $display("FAIL rst_first got=%b exp=0001", grant);
    end
    tick;
    checks++;
    if (dout !== dv[0] || dout_valid !== 1'b1) begin
      errors++;
      $display("FAIL rst_first_out dout=%h v=%b exp=%h/1",
               dout, dout_valid, dv[0]);
    end
  endtask

  task automatic test_round_robin;
    logic [3:0] eg [5];
    int ew [5];
    eg = '{4'b0001, 4'b0100, 4'b0010, 4'b1000, 4'b0001};
    ew = '{0, 2, 1, 3, 0};
    do_reset;
    req = 4'hf; out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      state = 1'(k % 2);
      #1;
      checks++;
      if (grant !== eg[k]) begin
        errors++;
        $display("FAIL rr_grant k=%0d got=%b exp=%b", k, grant, eg[k]);
      end
      tick;
      checks++;
      if (dout !== dv[ew[k]] || dout_valid !== 1'b1) begin
        errors++;
        $display("FAIL rr_dout k=%0d got=%h/%b exp=%h/1",
                 k, dout, dout_valid, dv[ew[k]]);
      end
    end
  endtask

  task automatic test_sparse;
    logic [3:0] eg [4];
    int ew [4];
    eg = '{4'b0001, 4'b0100, 4'b0001, 4'b1000};
    ew = '{0, 2, 0, 3};
    do_reset;
    req = 4'b1101; out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      state = 1'(k % 2);
      #1;
      checks++;
      if (grant !== eg[k]) begin
        errors++;
        $display("FAIL sparse_grant k=%0d got=%b exp=%b",
                 k, grant, eg[k]);
      end
      tick;
      checks++;
      if (dout !== dv[ew[k]]) begin
        errors++;
        $display("FAIL sparse_dout k=%0d got=%h exp=%h",
                 k, dout, dv[ew[k]]);
      end
    end
  endtask

  task automatic test_backpressure;
    do_reset;
    req = 4'hf; state = 1'b0; out_ready = 1'b1;
    tick;
    out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++;
      if (grant !== 4'b0000) begin
        errors++;
        $display("FAIL bp_grant c=%0d got=%b exp=0000", c, grant);
      end
      tick;
      checks++;
      if (dout !== dv[0] || dout_valid !== 1'b1) begin
        errors++;
        $display("FAIL bp_hold c=%0d got=%h/%b exp=%h/1",
                 c, dout, dout_valid, dv[0]);
      end
    end
    out_ready = 1'b1;
    #1;
    checks++;
    if (grant !== 4'b0010) begin
      errors++;
      $display("FAIL bp_release got=%b exp=0010", grant);
    end
    tick;
    checks++;
    if (dout !== dv[1] || dout_valid !== 1'b1) begin
      errors++;
      $display("FAIL bp_nobubble got=%h/%b exp=%h/1",
               dout, dout_valid, dv[1]);
    end
  endtask

  task automatic test_idle_vc;
    do_reset;
    req = 4'b0011; state = 1'b0; out_ready = 1'b1;
    tick;
    state = 1'b1;
    for (int c = 0; c < 2; c++) begin
      #1;
      checks++;
      if (grant !== 4'b0000) begin
        errors++;
        $display("FAIL idle_grant c=%0d got=%b exp=0000", c, grant);
      end
      tick;
      checks++;
      if (dout_valid !== 1'b0 || dout !== dv[0]) begin
        errors++;
        $display("FAIL idle_drain c=%0d got=%h/%b exp=%h/0",
                 c, dout, dout_valid, dv[0]);
      end
    end
  endtask

  task automatic test_reset_mid;
    do_reset;
    req = 4'hf; state = 1'b0; out_ready = 1'b0;
    tick;
    reset = 1'b1;
    #1;
    checks++;
    if (grant !== 4'b0000) begin
      errors++;
      $display("FAIL mid_grant got=%b exp=0000", grant);
    end
    tick;
    checks++;
    if (dout !== 64'h0 || dout_valid !== 1'b0) begin
      errors++;
      $display("FAIL mid_flush got=%h/%b exp=0/0", dout, dout_valid);
    end
    reset = 1'b0;
    #1;
    checks++;
    if (grant !== 4'b0001) begin
      errors++;
      $display("FAIL mid_ptr got=%b exp=0001", grant);
    end
    tick;
  endtask

  task automatic test_generic;
    logic [31:0] q [$];
    logic [31:0] exp_d;
    logic [11:0] pend;
    int w [12];
    int gi;
    int v;
    pend = '0;
    for (int j = 0; j < 12; j++) w[j] = 0;
    g_reset = 1'b1;
    tick;
    tick;
    g_reset = 1'b0;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      for (int j = 0; j < 12; j++) begin
        if (!pend[j] && $urandom_range(0, 2) == 0) pend[j] = 1'b1;
        g_data[j*32 +: 32] = $urandom;
      end
      g_req   = pend;
      g_state = 2'($urandom_range(0, 3));
      g_ready = ($urandom_range(0, 3) != 0);
      #1;
      checks++;
      if ((g_grant & (g_grant - 12'd1)) != 12'd0) begin
        errors++;
        $display("FAIL gen_onehot cyc=%0d got=%b", cyc, g_grant);
      end
      gi = -1;
      for (int j = 0; j < 12; j++) if (g_grant[j]) gi = j;
      checks++;
      if (gi < 0) begin
        if (g_req[int'(g_state)*3 +: 3] != 3'b000 &&
            (!g_valid || g_ready)) begin
          errors++;
          $display("FAIL gen_missed cyc=%0d req=%b st=%0d",
                   cyc, g_req, g_state);
        end
      end else if (!g_req[gi] || gi / 3 != int'(g_state) ||
                   (g_valid && !g_ready)) begin
        errors++;
        $display("FAIL gen_illegal cyc=%0d gnt=%b req=%b st=%0d",
                 cyc, g_grant, g_req, g_state);
      end
      if (g_valid && g_ready) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL gen_extra cyc=%0d got=%h exp=none",
                   cyc, g_dout);
        end else begin
          exp_d = q.pop_front();
          if (g_dout !== exp_d) begin
            errors++;
            $display("FAIL gen_data cyc=%0d got=%h exp=%h",
                     cyc, g_dout, exp_d);
          end
        end
      end
      if (gi >= 0) begin
        q.push_back(g_data[gi*32 +: 32]);
        v = gi / 3;
        for (int j = v * 3; j < v * 3 + 3; j++) begin
          if (j == gi) begin
            w[j] = 0;
          end else if (pend[j]) begin
            w[j]++;
            checks++;
            if (w[j] > 3) begin
              errors++;
              $display("FAIL gen_starve cyc=%0d req=%0d waited=%0d max=3",
                       cyc, j, w[j]);
            end
          end
        end
        pend[gi] = 1'b0;
      end
      tick;
    end
    checks++;
    if (q.size() != (g_valid ? 1 : 0)) begin
      errors++;
      $display("FAIL gen_leftover got=%0d exp=%0d",
               q.size(), g_valid ? 1 : 0);
    end
  endtask

  initial begin
    dv[0] = 64'h1fffffff00000000;
    dv[1] = 64'h17ffffff00000000;
    dv[2] = 64'h13ffffff00000000;
    dv[3] = 64'h11ffffff00000000;
    req_data = {dv[3], dv[2], dv[1], dv[0]};
    reset = 1'b1; state = 1'b0; req = '0; out_ready = 1'b1;
    g_reset = 1'b1; g_state = '0; g_req = '0;
    g_data = '0; g_ready = 1'b1;
    tick;
    test_reset;
    test_round_robin;
    test_sparse;
    test_backpressure;
    test_idle_vc;
    test_reset_mid;
    test_generic;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
